lvds_tx_lane_packer: RTL

//  Parametrised single-clock OpenLDI/FPD-Link transmit packer and 7:1 serializer, clocked at the 7x bit rate.

---
 rtl/lvds_tx_pkg.sv | 30 +++
 rtl/lvds_tx_fifo.sv | 49 ++++
 rtl/lvds_tx_lane_packer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/lvds_tx_pkg.sv
// rtl/lvds_tx_pkg.sv - shared types, clock-lane pattern and pixel-to-lane packing for the LVDS transmit packer
package lvds_tx_pkg;

  localparam logic [6:0] CLK_LANE_PATTERN = 7'b1100011;

  typedef logic [6:0] lane_word_t;
  typedef lane_word_t [3:0] lane_set_t;
  typedef enum logic {MAP_VESA, MAP_JEIDA} map_t;
  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  // Words are listed bit6 first; 6-bit colour is passed zero-extended and always uses MAP_VESA.
  function automatic lane_set_t pack_pixel(input logic hs, input logic vs, input logic de,
                                           input logic [7:0] r, input logic [7:0] g,
                                           input logic [7:0] b, input map_t map);
    lane_set_t w;
    if (map == MAP_JEIDA) begin
      w[0] = {r[2], r[3], r[4], r[5], r[6], r[7], g[2]};
      w[1] = {g[3], g[4], g[5], g[6], g[7], b[2], b[3]};
      w[2] = {b[4], b[5], b[6], b[7], hs, vs, de};
      w[3] = {r[0], r[1], g[0], g[1], b[0], b[1], 1'b0};
    end else begin
      w[0] = {r[0], r[1], r[2], r[3], r[4], r[5], g[0]};
      w[1] = {g[1], g[2], g[3], g[4], g[5], b[0], b[1]};
      w[2] = {b[2], b[3], b[4], b[5], hs, vs, de};
      w[3] = {r[6], r[7], g[6], g[7], b[6], b[7], 1'b0};
    end
    return w;
  endfunction

endpackage

// File: rtl/lvds_tx_fifo.sv
// rtl/lvds_tx_fifo.sv - synchronous pixel FIFO with full/empty flags and flush
module lvds_tx_fifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/lvds_tx_lane_packer.sv
// rtl/lvds_tx_lane_packer.sv - OpenLDI 7:1 lane packer/serializer; LVDS_TX_UFLOW_CNT_EN adds uflow_count
module lvds_tx_lane_packer
  import lvds_tx_pkg::*;
#(
  parameter  int COLOR_BITS = 8,
  parameter  int FIFO_DEPTH = 4,
  localparam int LANES      = (COLOR_BITS == 8) ? 4 : 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  map_jeida,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_hsync,
  input  logic                  s_vsync,
  input  logic                  s_de,
  input  logic [COLOR_BITS-1:0] s_red,
  input  logic [COLOR_BITS-1:0] s_green,
  input  logic [COLOR_BITS-1:0] s_blue,
  output logic [LANES-1:0]      lane_out,
  output logic                  clk_lane_out,
  output logic                  slot_start,
  output logic                  underflow
`ifdef LVDS_TX_UFLOW_CNT_EN
  ,
  output logic [15:0]           uflow_count
`endif
);

  localparam int PW = 3*COLOR_BITS + 3;

  state_t                  state;
  logic [2:0]              phase;
  logic [LANES-1:0][6:0]   shift_q;
  logic                    held_hs;
  logic                    held_vs;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    push;
  logic                    pop;
  logic                    load;
  logic [PW-1:0]           fifo_din;
  logic [PW-1:0]           fifo_dout;
  logic [7:0]              r8;
  logic [7:0]              g8;
  logic [7:0]              b8;
  logic                    px_hs;
  logic                    px_vs;
  logic                    px_de;
  map_t                    map_sel;
  lane_set_t               words;

  assign s_ready  = (state == ST_RUN) && !fifo_full;
  assign push     = s_valid && s_ready;
  // A new slot loads on leaving IDLE or at the end of phase 6 while still enabled.
  assign load     = en && ((state == ST_IDLE) || (phase == 3'd6));
  assign pop      = load && !fifo_empty;
  assign fifo_din = {s_hsync, s_vsync, s_de, s_red, s_green, s_blue};

  lvds_tx_fifo #(.WIDTH(PW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (state == ST_IDLE),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    r8      = '0;
    g8      = '0;
    b8      = '0;
    px_hs   = held_hs;
    px_vs   = held_vs;
    px_de   = 1'b0;
    map_sel = (COLOR_BITS == 8 && map_jeida) ? MAP_JEIDA : MAP_VESA;
    if (!fifo_empty) begin
      {px_hs, px_vs, px_de} = fifo_dout[PW-1 -: 3];
      r8[COLOR_BITS-1:0]    = fifo_dout[3*COLOR_BITS-1 -: COLOR_BITS];
      g8[COLOR_BITS-1:0]    = fifo_dout[2*COLOR_BITS-1 -: COLOR_BITS];
      b8[COLOR_BITS-1:0]    = fifo_dout[COLOR_BITS-1:0];
    end
    words = pack_pixel(px_hs, px_vs, px_de, r8, g8, b8, map_sel);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      phase        <= 3'd6;
      shift_q      <= '0;
      held_hs      <= 1'b0;
      held_vs      <= 1'b0;
      lane_out     <= '0;
      clk_lane_out <= 1'b0;
      slot_start   <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      slot_start <= 1'b0;
      underflow  <= 1'b0;
      if (load) begin
        state        <= ST_RUN;
        phase        <= 3'd0;
        clk_lane_out <= CLK_LANE_PATTERN[6];
        slot_start   <= 1'b1;
        underflow    <= fifo_empty;
        if (!fifo_empty) begin
          held_hs <= px_hs;
          held_vs <= px_vs;
        end
        for (int i = 0; i < LANES; i++) begin
          lane_out[i] <= words[i][6];
          shift_q[i]  <= {words[i][5:0], 1'b0};
        end
      end else if (state == ST_RUN && phase == 3'd6) begin
        state        <= ST_IDLE;
        lane_out     <= '0;
        clk_lane_out <= 1'b0;
        shift_q      <= '0;
      end else if (state == ST_RUN) begin
        phase        <= phase + 3'd1;
        clk_lane_out <= CLK_LANE_PATTERN[3'd5 - phase];
        for (int i = 0; i < LANES; i++) begin
          lane_out[i] <= shift_q[i][6];
          shift_q[i]  <= {shift_q[i][5:0], 1'b0};
        end
      end
    end
  end

`ifdef LVDS_TX_UFLOW_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uflow_count <= '0;
    end else if (load && fifo_empty && uflow_count != 16'hFFFF) begin
      uflow_count <= uflow_count + 16'd1;
    end
  end
`endif

endmodule
